instruction_fetch_unit: RTL and testbench

Fetch stage directly upstream of instruction_memory, which is a combinational word read (addr -> out in the same cycle). It owns the fetch PC, drives the memory address, and captures {pc, instr} pairs into a small prefetch FIFO. The FIFO feeds decode over a valid/ready handshake. It handles branch/jump redirects with a flush and raises a sticky fault on misaligned or out-of-range fetch addresses.

---
 rtl/fetch_pkg.sv | 32 +++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/instruction_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int ENTRY_W = 2 * XLEN;

    localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Word-aligned and strictly below the memory size (unsigned compare).
    function automatic logic pc_is_legal(input logic [XLEN-1:0] pc,
                                         input logic [XLEN-1:0] limit);
        return (pc[1:0] == 2'b00) && (pc < limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry circular prefetch buffer of {pc, instr} entries.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_wdata,
    input  logic         i_pop,
    output fetch_entry_t o_rdata,
    output logic         o_empty,
    output logic         o_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    fetch_entry_t r_mem [DEPTH];

    logic w_push_en;
    logic w_pop_en;

    // The extra pointer bit distinguishes full from empty when indices match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_pop_en  = i_pop & ~o_empty;
    assign w_push_en = i_push & (~o_full | w_pop_en) & ~i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Fetch PC, prefetch FIFO, redirect flush and sticky fetch fault.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          DEPTH      = 2,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] inst_mem_addr,
    input  logic [31:0] inst_mem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_fault
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_fault;

    fetch_state_t    w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_fault_nxt;
    logic            w_push;
    logic            w_flush;
    logic            w_pop;
    logic            w_legal;
    logic            w_empty;
    logic            w_full;
    fetch_entry_t    w_wdata;
    fetch_entry_t    w_rdata;

    assign w_legal = pc_is_legal(r_pc, ADDR_LIMIT);
    assign w_pop   = ~w_empty & out_ready;
    assign w_wdata = '{pc: r_pc, instr: inst_mem_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_fault_nxt = r_fault;
        w_push      = 1'b0;
        w_flush     = 1'b0;
        // A redirect outranks everything once out of BOOT; a head popped
        // this cycle is still delivered because decode already took it.
        if (redirect_valid && (r_state != ST_BOOT)) begin
            w_flush     = 1'b1;
            w_pc_nxt    = redirect_pc;
            w_state_nxt = ST_RUN;
            w_fault_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    w_state_nxt = ST_RUN;
                    if (redirect_valid) begin
                        w_pc_nxt = redirect_pc;
                    end
                end
                ST_RUN: begin
                    if (!w_legal) begin
                        w_state_nxt = ST_FAULT;
                        w_fault_nxt = 1'b1;
                    end else if (!w_full || w_pop) begin
                        w_push   = 1'b1;
                        w_pc_nxt = r_pc + INSTR_BYTES;
                    end
                end
                ST_FAULT: begin
                    w_state_nxt = ST_FAULT;
                end
                default: begin
                    w_state_nxt = ST_BOOT;
                    w_fault_nxt = 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign inst_mem_addr = r_pc;
    assign fetch_fault   = r_fault;
    assign out_valid     = ~w_empty;
    assign out_pc        = w_empty ? '0 : w_rdata.pc;
    assign out_instr     = w_empty ? '0 : w_rdata.instr;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed self-checking bench for instruction_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst_mem_addr;
    logic [31:0] inst_mem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    instruction_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .DEPTH      (2),
        .ADDR_LIMIT (32'h0000_1000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .inst_mem_addr  (inst_mem_addr),
        .inst_mem_data  (inst_mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_fault    (fetch_fault)
    );

    // Combinational instruction memory model.
    assign inst_mem_data = inst_mem_addr ^ 32'hA5A5_0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", fetch_fault); end
        checks++; if (inst_mem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 00000000", inst_mem_addr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 00000000", out_pc); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 00000000", out_instr); end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL s_valid: got %b expected 1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL s_pc0: got %h expected 00000000", out_pc); end
        checks++; if (out_instr !== 32'hA5A5_0000) begin errors++; $display("FAIL s_instr0: got %h expected a5a50000", out_instr); end
        tick();
        checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL s_pc4: got %h expected 00000004", out_pc); end
        checks++; if (out_instr !== 32'hA5A5_0004) begin errors++; $display("FAIL s_instr4: got %h expected a5a50004", out_instr); end
        tick();
        checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL s_pc8: got %h expected 00000008", out_pc); end
        checks++; if (out_instr !== 32'hA5A5_0008) begin errors++; $display("FAIL s_instr8: got %h expected a5a50008", out_instr); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        do_reset();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL bp_hold%0d: got valid=%b pc=%h expected valid=1 pc=00000000", i, out_valid, out_pc); end
        end
        checks++; if (inst_mem_addr !== 32'h8) begin errors++; $display("FAIL bp_addr: got %h expected 00000008", inst_mem_addr); end
        checks++; if (out_instr !== 32'hA5A5_0000) begin errors++; $display("FAIL bp_instr: got %h expected a5a50000", out_instr); end
        out_ready = 1'b1;
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL bp_r0: got %h expected 00000000", out_pc); end
        tick();
        checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL bp_r4: got %h expected 00000004", out_pc); end
        tick();
        checks++; if (out_pc !== 32'h8) begin errors++; $display("FAIL bp_r8: got %h expected 00000008", out_pc); end
        tick();
        checks++; if (out_pc !== 32'hC) begin errors++; $display("FAIL bp_rC: got %h expected 0000000c", out_pc); end
    endtask

    task automatic test_redirect_full();
        out_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        checks++; if (inst_mem_addr !== 32'h8) begin errors++; $display("FAIL rf_full_addr: got %h expected 00000008", inst_mem_addr); end
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h3DC;
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL rf_head: got valid=%b pc=%h expected valid=1 pc=00000000", out_valid, out_pc); end
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_flushed: got %b expected 0", out_valid); end
        checks++; if (inst_mem_addr !== 32'h3DC) begin errors++; $display("FAIL rf_addr: got %h expected 000003dc", inst_mem_addr); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3DC) begin errors++; $display("FAIL rf_pc3dc: got valid=%b pc=%h expected valid=1 pc=000003dc", out_valid, out_pc); end
        checks++; if (out_instr !== 32'hA5A5_03DC) begin errors++; $display("FAIL rf_instr: got %h expected a5a503dc", out_instr); end
        tick();
        checks++; if (out_pc !== 32'h3E0) begin errors++; $display("FAIL rf_pc3e0: got %h expected 000003e0", out_pc); end
        tick();
        checks++; if (out_pc !== 32'h3E4) begin errors++; $display("FAIL rf_pc3e4: got %h expected 000003e4", out_pc); end
    endtask

    task automatic test_fault_boundary();
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFF8;
        tick();
        redirect_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fb_flush: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFF8) begin errors++; $display("FAIL fb_ff8: got valid=%b pc=%h expected valid=1 pc=00000ff8", out_valid, out_pc); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFC) begin errors++; $display("FAIL fb_ffc: got valid=%b pc=%h expected valid=1 pc=00000ffc", out_valid, out_pc); end
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fb_nofault: got %b expected 0", fetch_fault); end
        tick();
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL fb_fault: got %b expected 1", fetch_fault); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fb_drained: got %b expected 0", out_valid); end
        checks++; if (inst_mem_addr !== 32'h1000) begin errors++; $display("FAIL fb_addr: got %h expected 00001000", inst_mem_addr); end
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (fetch_fault !== 1'b1 || out_valid !== 1'b0 || inst_mem_addr !== 32'h1000) begin errors++; $display("FAIL fb_hold%0d: got fault=%b valid=%b addr=%h expected fault=1 valid=0 addr=00001000", i, fetch_fault, out_valid, inst_mem_addr); end
        end
    endtask

    task automatic test_fault_recover();
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL fr_clear: got %b expected 0", fetch_fault); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h10) begin errors++; $display("FAIL fr_pc10: got valid=%b pc=%h expected valid=1 pc=00000010", out_valid, out_pc); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h12;
        tick();
        redirect_valid = 1'b0;
        checks++; if (fetch_fault !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL fr_mis_r: got fault=%b valid=%b expected fault=0 valid=0", fetch_fault, out_valid); end
        tick();
        checks++; if (fetch_fault !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL fr_mis_f: got fault=%b valid=%b expected fault=1 valid=0", fetch_fault, out_valid); end
        checks++; if (inst_mem_addr !== 32'h12) begin errors++; $display("FAIL fr_mis_addr: got %h expected 00000012", inst_mem_addr); end
    endtask

    task automatic test_boot_redirect();
        out_ready = 1'b1;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        checks++; if (inst_mem_addr !== 32'h40 || out_valid !== 1'b0) begin errors++; $display("FAIL br_addr: got addr=%h valid=%b expected addr=00000040 valid=0", inst_mem_addr, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40) begin errors++; $display("FAIL br_pc40: got valid=%b pc=%h expected valid=1 pc=00000040", out_valid, out_pc); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        checks++; if (fetch_fault !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'hFFC) begin errors++; $display("FAIL ar_pre: got fault=%b valid=%b pc=%h expected fault=1 valid=1 pc=00000ffc", fetch_fault, out_valid, out_pc); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || fetch_fault !== 1'b0) begin errors++; $display("FAIL ar_async: got valid=%b fault=%b expected valid=0 fault=0", out_valid, fetch_fault); end
        checks++; if (inst_mem_addr !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("FAIL ar_addr: got addr=%h pc=%h expected addr=00000000 pc=00000000", inst_mem_addr, out_pc); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_boot: got %b expected 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA5A5_0000) begin errors++; $display("FAIL ar_pc0: got valid=%b pc=%h instr=%h expected valid=1 pc=00000000 instr=a5a50000", out_valid, out_pc, out_instr); end
        tick();
        checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL ar_pc4: got %h expected 00000004", out_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_fault_boundary();
        test_fault_recover();
        test_boot_redirect();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
